fmap_ram_reader: RTL and testbench

Streams stored feature-map data back out of the top or side buffer RAM. Addresses follow the same layout the write side uses: feature `f`, word `w` sits at `f*W + w`, where `W` is fixed by conv layer and RAM select. The block issues synchronous single-cycle RAM reads and repacks the returned words into a valid/ready stream with per-word tags. It sits between the buffer RAMs and the downstream conv/FC datapath.

---
 rtl/fmap_ram_reader_if.sv | 40 ++++
 rtl/fmap_ram_reader.sv | 172 +++++++++++++++++
 tb/tb_fmap_ram_reader.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/fmap_ram_reader_if.sv
// Bundles the control, RAM-read and output-stream signals of fmap_ram_reader.
// The master modport is the reader; the slave modport is its environment.
interface fmap_ram_reader_if #(
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned ADDR_WIDTH = 13
);
   logic                  start_i;
   logic [2:0]            conv_layer_index_i;
   logic [8:0]            feature_last_i;
   logic                  sel_side_i;
   logic                  busy_o;
   logic                  done_o;
   logic                  ram_rd_en_o;
   logic [ADDR_WIDTH-1:0] ram_rd_addr_o;
   logic [DATA_WIDTH-1:0] ram_rd_data_i;
   logic [DATA_WIDTH-1:0] data_o;
   logic                  data_valid_o;
   logic                  data_ready_i;
   logic [8:0]            feature_index_o;
   logic                  word_last_o;
   logic                  frame_last_o;

   modport master (
      input  start_i, conv_layer_index_i, feature_last_i, sel_side_i,
      output busy_o, done_o,
      output ram_rd_en_o, ram_rd_addr_o,
      input  ram_rd_data_i,
      output data_o, data_valid_o, feature_index_o, word_last_o, frame_last_o,
      input  data_ready_i
   );

   modport slave (
      output start_i, conv_layer_index_i, feature_last_i, sel_side_i,
      input  busy_o, done_o,
      input  ram_rd_en_o, ram_rd_addr_o,
      output ram_rd_data_i,
      input  data_o, data_valid_o, feature_index_o, word_last_o, frame_last_o,
      output data_ready_i
   );
endinterface

// File: rtl/fmap_ram_reader.sv
// Reads a stored feature map out of the top/side buffer RAM and repacks it into a
// valid/ready stream with feature index and last-word tags.
module fmap_ram_reader #(
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned ADDR_WIDTH = 13
) (
   input logic               clk_i,
   input logic               rst_n,
   fmap_ram_reader_if.master bus
);

   typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

   state_e state_q, state_d;

   logic [2:0] layer_q;
   logic [8:0] feat_last_q;
   logic       side_q;
   logic [4:0] word_q;
   logic [8:0] feat_q;

   logic       inflight_q;
   logic [8:0] infl_feat_q;
   logic       infl_wl_q;
   logic       infl_fl_q;

   logic [DATA_WIDTH-1:0] fifo_data_q [2];
   logic [8:0]            fifo_feat_q [2];
   logic [1:0]            fifo_wl_q;
   logic [1:0]            fifo_fl_q;
   logic                  wr_ptr_q;
   logic                  rd_ptr_q;
   logic [1:0]            occ_q;

   logic                  start_acc;
   logic                  start_invalid;
   logic [2:0]            w_shift;
   logic [4:0]            word_max;
   logic [ADDR_WIDTH-1:0] rd_addr;
   logic                  word_last_now;
   logic                  frame_last_now;
   logic                  valid;
   logic                  pop;
   logic                  credit_ok;
   logic                  issue;

   assign start_acc     = (state_q == StIdle) && bus.start_i;
   assign start_invalid = !bus.sel_side_i && (bus.conv_layer_index_i[2:1] == 2'b11);

   // W = 1 << w_shift, derived from the captured layer and RAM select
   always_comb begin
      w_shift = 3'd0;
      if (side_q) begin
         w_shift = 3'd3;
      end else begin
         case (layer_q)
            3'd0, 3'd1: w_shift = 3'd4;
            3'd2:       w_shift = 3'd3;
            3'd3:       w_shift = 3'd2;
            3'd4:       w_shift = 3'd1;
            default:    w_shift = 3'd0;
         endcase
      end
   end

   assign word_max       = 5'b11111 >> (3'd5 - w_shift);
   assign rd_addr        = (ADDR_WIDTH'(feat_q) << w_shift) + ADDR_WIDTH'(word_q);
   assign word_last_now  = (word_q == word_max);
   assign frame_last_now = word_last_now && (feat_q == feat_last_q);

   assign valid = (occ_q != 2'd0);
   assign pop   = valid && bus.data_ready_i;
   // occupancy + inflight - pop < 2, kept non-negative
   assign credit_ok = ({1'b0, occ_q} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop});
   assign issue     = (state_q == StRun) && credit_ok;

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (bus.start_i) state_d = start_invalid ? StDone : StRun;
         end
         StRun: begin
            if (issue && frame_last_now) state_d = StDrain;
         end
         StDrain: begin
            if (!inflight_q && ((occ_q == 2'd0) || ((occ_q == 2'd1) && pop))) state_d = StDone;
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         layer_q     <= '0;
         feat_last_q <= '0;
         side_q      <= 1'b0;
         word_q      <= '0;
         feat_q      <= '0;
      end else begin
         state_q <= state_d;
         if (start_acc) begin
            layer_q     <= bus.conv_layer_index_i;
            feat_last_q <= bus.feature_last_i;
            side_q      <= bus.sel_side_i;
            word_q      <= '0;
            feat_q      <= '0;
         end else if (issue) begin
            if (word_last_now) begin
               word_q <= '0;
               feat_q <= feat_q + 9'd1;
            end else begin
               word_q <= word_q + 5'd1;
            end
         end
      end
   end

   // Tags travel alongside the one-cycle RAM read latency
   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         inflight_q  <= 1'b0;
         infl_feat_q <= '0;
         infl_wl_q   <= 1'b0;
         infl_fl_q   <= 1'b0;
      end else begin
         inflight_q <= issue;
         if (issue) begin
            infl_feat_q <= feat_q;
            infl_wl_q   <= word_last_now;
            infl_fl_q   <= frame_last_now;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         fifo_data_q[0] <= '0;
         fifo_data_q[1] <= '0;
         fifo_feat_q[0] <= '0;
         fifo_feat_q[1] <= '0;
         fifo_wl_q      <= '0;
         fifo_fl_q      <= '0;
         wr_ptr_q       <= 1'b0;
         rd_ptr_q       <= 1'b0;
         occ_q          <= '0;
      end else begin
         if (inflight_q) begin
            fifo_data_q[wr_ptr_q] <= bus.ram_rd_data_i;
            fifo_feat_q[wr_ptr_q] <= infl_feat_q;
            fifo_wl_q[wr_ptr_q]   <= infl_wl_q;
            fifo_fl_q[wr_ptr_q]   <= infl_fl_q;
            wr_ptr_q              <= ~wr_ptr_q;
         end
         if (pop) rd_ptr_q <= ~rd_ptr_q;
         occ_q <= occ_q + {1'b0, inflight_q} - {1'b0, pop};
      end
   end

   assign bus.busy_o          = (state_q != StIdle);
   assign bus.done_o          = (state_q == StDone);
   assign bus.ram_rd_en_o     = issue;
   assign bus.ram_rd_addr_o   = issue ? rd_addr : '0;
   assign bus.data_valid_o    = valid;
   assign bus.data_o          = valid ? fifo_data_q[rd_ptr_q] : '0;
   assign bus.feature_index_o = valid ? fifo_feat_q[rd_ptr_q] : '0;
   assign bus.word_last_o     = valid && fifo_wl_q[rd_ptr_q];
   assign bus.frame_last_o    = valid && fifo_fl_q[rd_ptr_q];

endmodule

// File: tb/tb_fmap_ram_reader.sv
// Randomised bench for fmap_ram_reader: a RAM model plus a per-transfer queue of
// expected words built from the address layout, checked at every handshake.
module tb_fmap_ram_reader;
   localparam int DW = 16;
   localparam int AW = 13;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   fmap_ram_reader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

   fmap_ram_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clk_i (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   logic [DW-1:0] ram [1 << AW];
   always @(posedge clk) if (bus.ram_rd_en_o) bus.ram_rd_data_i <= ram[bus.ram_rd_addr_o];

   typedef struct {
      logic [DW-1:0] data;
      int            feat;
      bit            wl;
      bit            fl;
   } word_t;

   word_t exp_q[$];
   int    addr_q[$];
   int    n_checks = 0;
   int    n_fail = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int words_per_feature(input int layer, input bit side);
      int tbl [8] = '{16, 16, 8, 4, 2, 1, 0, 0};
      return side ? 8 : tbl[layer];
   endfunction

   task automatic check_outputs_zero(input string tag);
      check_eq({tag, "_ctl"}, {bus.busy_o, bus.done_o, bus.ram_rd_en_o, bus.data_valid_o,
                               bus.word_last_o, bus.frame_last_o, bus.feature_index_o}, 0);
      check_eq({tag, "_bus"}, {bus.ram_rd_addr_o, bus.data_o}, 0);
   endtask

   // rmode: 0 ready held high, 1 ready pattern 1,0,0,1, 2 random ready and input scrambling
   task automatic run_xfer(input int layer, input int fl, input bit side, input int rmode,
                           input int rst_after);
      int            w, total, cyc, hs, nrd, last_hs, first_vld, a;
      bit            stall, done_seen;
      logic [DW-1:0] s_data;
      logic [8:0]    s_feat;
      logic          s_wl, s_fl;
      word_t         e;
      int            pat [4] = '{1, 0, 0, 1};

      w = words_per_feature(layer, side);
      exp_q.delete();
      addr_q.delete();
      for (int f = 0; f <= fl && w > 0; f++) begin
         for (int k = 0; k < w; k++) begin
            a = (f * w + k) % (1 << AW);
            addr_q.push_back(a);
            exp_q.push_back('{ram[a], f, k == w - 1, (k == w - 1) && (f == fl)});
         end
      end
      total = exp_q.size();

      @(negedge clk);
      check_eq("idle_before_start", {bus.busy_o, bus.data_valid_o}, 0);
      bus.start_i            = 1'b1;
      bus.conv_layer_index_i = 3'(layer);
      bus.feature_last_i     = 9'(fl);
      bus.sel_side_i         = side;
      bus.data_ready_i       = 1'b1;

      cyc = 0; hs = 0; nrd = 0; last_hs = 0; first_vld = 0;
      stall = 1'b0; done_seen = 1'b0;
      s_data = '0; s_feat = '0; s_wl = 1'b0; s_fl = 1'b0;
      while (!done_seen && cyc < 20000) begin
         @(negedge clk);
         cyc++;
         if (rmode == 2) begin
            bus.start_i            = 1'($urandom_range(0, 1));
            bus.conv_layer_index_i = 3'($urandom_range(0, 7));
            bus.feature_last_i     = 9'($urandom_range(0, 511));
            bus.sel_side_i         = 1'($urandom_range(0, 1));
            bus.data_ready_i       = 1'($urandom_range(0, 1));
         end else begin
            bus.start_i      = 1'b0;
            bus.data_ready_i = (rmode == 1) ? 1'(pat[(cyc - 1) % 4]) : 1'b1;
         end
         #1;
         if (stall) begin
            check_eq("stall_valid", bus.data_valid_o, 1);
            check_eq("stall_data", bus.data_o, s_data);
            check_eq("stall_tags", {bus.feature_index_o, bus.word_last_o, bus.frame_last_o},
                     {s_feat, s_wl, s_fl});
         end
         if (bus.ram_rd_en_o) begin
            if (nrd == 0) check_eq("first_read_cycle", cyc, 1);
            if (addr_q.size() == 0) check_eq("extra_read", bus.ram_rd_addr_o, 32'hffff_ffff);
            else check_eq("read_addr", bus.ram_rd_addr_o, addr_q.pop_front());
            nrd++;
         end
         if (bus.data_valid_o && first_vld == 0) begin
            first_vld = cyc;
            check_eq("first_valid_cycle", cyc, 3);
         end
         if (bus.data_valid_o && bus.data_ready_i) begin
            hs++;
            last_hs = cyc;
            if (exp_q.size() == 0) begin
               check_eq("extra_word", bus.data_o, 32'hffff_ffff);
            end else begin
               e = exp_q.pop_front();
               check_eq("word_data", bus.data_o, e.data);
               check_eq("word_feat", bus.feature_index_o, e.feat);
               check_eq("word_last", bus.word_last_o, e.wl);
               check_eq("frame_last", bus.frame_last_o, e.fl);
            end
            if (hs == rst_after) begin
               rst_n = 1'b0;
               #1;
               check_outputs_zero("reset_mid");
               bus.start_i = 1'b0;
               @(negedge clk);
               rst_n = 1'b1;
               @(negedge clk);
               #1;
               check_outputs_zero("after_reset");
               return;
            end
         end
         stall  = bus.data_valid_o && !bus.data_ready_i;
         s_data = bus.data_o;
         s_feat = bus.feature_index_o;
         s_wl   = bus.word_last_o;
         s_fl   = bus.frame_last_o;
         check_eq("busy_high", bus.busy_o, 1);
         if (bus.done_o) begin
            done_seen = 1'b1;
            check_eq("done_cycle", cyc, (total == 0) ? 1 : last_hs + 1);
            check_eq("words_delivered", hs, total);
            check_eq("reads_issued", nrd, total);
            if (rmode == 0 && total > 0) check_eq("full_rate_done", cyc, total + 3);
         end
      end
      if (!done_seen) check_eq("done_timeout", 0, 1);
      @(negedge clk);
      bus.start_i = 1'b0;
      #1;
      check_eq("idle_after_done", {bus.busy_o, bus.done_o, bus.data_valid_o}, 0);
   endtask

   initial begin
      for (int i = 0; i < (1 << AW); i++) ram[i] = DW'($urandom);
      bus.start_i            = 1'b0;
      bus.conv_layer_index_i = '0;
      bus.feature_last_i     = '0;
      bus.sel_side_i         = 1'b0;
      bus.data_ready_i       = 1'b0;
      repeat (3) @(negedge clk);
      check_outputs_zero("reset_state");
      rst_n = 1'b1;

      run_xfer(5, 2, 1'b0, 0, 0);
      run_xfer(0, 3, 1'b0, 0, 0);
      run_xfer(3, 1, 1'b1, 0, 0);
      run_xfer(2, 1, 1'b0, 1, 0);
      run_xfer(6, 5, 1'b0, 0, 0);
      run_xfer(7, 0, 1'b0, 2, 0);
      run_xfer(0, 3, 1'b0, 0, 5);
      run_xfer(0, 3, 1'b0, 0, 0);
      run_xfer(0, 511, 1'b0, 0, 0);
      for (int t = 0; t < 10; t++) begin
         run_xfer($urandom_range(0, 7), $urandom_range(0, 40), 1'($urandom_range(0, 1)),
                  $urandom_range(0, 2), 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
